// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Multiplies by 32-step shift-add and divides by 32-step restoring
// shift-subtract on operand magnitudes, then applies sign correction in a
// single FIX cycle before committing the result to HI/LO.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_mag_b;
    logic [63:0] r_acc;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    // Operand magnitudes at the moment an operation is accepted
    logic        w_in_signed;
    logic [31:0] w_mag_a_in;
    logic [31:0] w_mag_b_in;
    logic        w_accept;
    logic        w_last;

    // One multiply iteration: conditionally add multiplicand, shift right
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    // One restoring-divide iteration: shift left, trial subtract
    logic [32:0] w_div_up;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_div_next;

    // Sign correction of the raw magnitude result
    logic        w_op_signed;
    logic        w_is_div;
    logic        w_div_zero;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_in_signed = ~op[0];
    assign w_mag_a_in  = (w_in_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_mag_b_in  = (w_in_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_last      = (r_cnt == 6'd31);

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    assign w_div_up   = r_acc[63:31];
    assign w_div_diff = w_div_up - {1'b0, r_mag_b};
    assign w_div_ge   = ~w_div_diff[32];
    assign w_div_next = {(w_div_ge ? w_div_diff[31:0] : w_div_up[31:0]), r_acc[30:0], w_div_ge};

    assign w_op_signed = ~r_op[0];
    assign w_is_div    = r_op[1];
    assign w_div_zero  = (r_b == 32'd0);
    assign w_prod      = (w_op_signed && (r_a[31] ^ r_b[31])) ? (64'd0 - r_acc) : r_acc;
    assign w_quot      = (w_op_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem       = (w_op_signed && r_a[31]) ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // Select the committed HI/LO value; divide-by-zero returns the raw dividend
    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (w_is_div) begin
            if (w_div_zero) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: IDLE -> CALC (32 cycles) -> FIX (1 cycle) -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: busy covers CALC and FIX; done is the registered pulse
    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_FIX);
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

    // Operand latch, iteration counter and accumulator/remainder datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_mag_b <= 32'd0;
            r_acc   <= 64'd0;
            r_cnt   <= 6'd0;
        end else if (w_accept) begin
            r_op    <= op;
            r_a     <= src_a;
            r_b     <= src_b;
            r_mag_b <= w_mag_b_in;
            r_acc   <= {32'd0, w_mag_a_in};
            r_cnt   <= 6'd0;
        end else if (r_state == S_CALC) begin
            r_acc   <= w_is_div ? w_div_next : w_mul_next;
            r_cnt   <= r_cnt + 6'd1;
        end
    end

    // HI/LO: moves only in IDLE without start, results only when leaving FIX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_state == S_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if ((r_state == S_IDLE) && !start) begin
            if (mthi) r_hi <= src_a;
            if (mtlo) r_lo <= src_a;
        end
    end

    // Completion pulse in the cycle after FIX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed operations with a
// scoreboard of expected {hi,lo}, latency/busy/done timing checks,
// mthi/mtlo behaviour, ignored start while busy and asynchronous abort.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Independent reference: 64-bit arithmetic with SV truncating division
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [63:0]        p;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        p   = 64'd0;
        case (o)
            2'b00: p = sa * sbv;
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // inj_kind: 0 none, 1 second start at cycle N+inj_k, 2 mthi/mtlo at N+inj_k
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] expv,
                          input int inj_k, input int inj_kind, input bit with_mt);
        logic [63:0] old;
        logic [63:0] popped;
        int          k;
        int          bc;
        int          dk;
        int          extra;
        bit          got;
        bit          hold_ok;
        logic        busy_at_done;
        old = {hi, lo};
        exp_q.push_back(expv);
        op = o; src_a = a; src_b = b; start = 1'b1;
        mthi = with_mt; mtlo = with_mt;
        step();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        k = 1; bc = 0; dk = 0; got = 1'b0; hold_ok = 1'b1; busy_at_done = 1'b1;
        while (k <= 45 && !got) begin
            if (busy) begin
                bc++;
                if ({hi, lo} !== old) hold_ok = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                dk = k;
                busy_at_done = busy;
            end else begin
                if (k == inj_k && inj_kind == 1) begin
                    start = 1'b1; op = 2'b01; src_a = 32'd123; src_b = 32'd456;
                end else if (k == inj_k && inj_kind == 2) begin
                    mthi = 1'b1; mtlo = 1'b1; src_a = 32'hDEAD_BEEF;
                end
                step();
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
                k++;
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        popped = exp_q.pop_front();
        if (got) begin
            chk({tag, "_latency"}, 64'(dk), 64'd34);
            chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
            chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
            chk({tag, "_hilo_hold"}, 64'(hold_ok), 64'd1);
            chk({tag, "_result"}, {hi, lo}, popped);
        end
        $display("op %s a=%h b=%h hi=%h lo=%h lat=%0d busy=%0d", tag, a, b, hi, lo, dk, bc);
        step();
        chk({tag, "_done_pulse_end"}, 64'(done), 64'd0);
        if (inj_kind == 1) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) extra++;
                step();
            end
            chk({tag, "_no_second_done"}, 64'(extra), 64'd0);
            chk({tag, "_result_kept"}, {hi, lo}, popped);
        end
    endtask

    initial begin
        int          k;
        int          extra;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;

        rst = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        #10 rst = 1'b1;
        step();

        // mthi then mtlo, then both together
        src_a = 32'h1234_5678; mthi = 1'b1;
        step();
        mthi = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo_kept", 64'(lo), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        $display("op mthi a=%h hi=%h lo=%h", 32'h1234_5678, hi, lo);
        src_a = 32'h9; mtlo = 1'b1;
        step();
        mtlo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h9);
        chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
        chk("mtlo_done", 64'(done), 64'd0);
        $display("op mtlo a=%h hi=%h lo=%h", 32'h9, hi, lo);
        src_a = 32'hA5A5_0F0F; mthi = 1'b1; mtlo = 1'b1;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_both", {hi, lo}, 64'hA5A5_0F0F_A5A5_0F0F);
        $display("op mthi+mtlo a=%h hi=%h lo=%h", 32'hA5A5_0F0F, hi, lo);

        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0, 1'b0);
        run_op("multu_max_start_wins", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, 1'b1);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 1'b0);
        run_op("divu_100_0", 2'b11, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 0, 0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
        run_op("div_neg5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 0, 0, 1'b0);
        run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 0, 1'b0);
        run_op("multu_5x5_restart", 2'b01, 32'd5, 32'd5, 64'h0000_0000_0000_0019, 10, 1, 1'b0);
        run_op("mult_mthi_busy", 2'b00, 32'd1234, 32'hFFFF_E9D2,
               model(2'b00, 32'd1234, 32'hFFFF_E9D2), 5, 2, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ro = 2'(i);
            ra = $urandom;
            rb = $urandom;
            if (i >= 2) rb = rb >> (i * 6);
            run_op("rand", ro, ra, rb, model(ro, ra, rb), 0, 0, 1'b0);
        end

        // Asynchronous abort in cycle N+15 of a DIV
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        while (k < 15) begin
            step();
            k++;
        end
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        $display("op abort_div a=%h b=%h hi=%h lo=%h", 32'd1000, 32'd3, hi, lo);
        step();
        step();
        #2 rst = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) extra++;
        end
        chk("abort_no_done_after", 64'(extra), 64'd0);
        chk("abort_hilo_after", {hi, lo}, 64'd0);

        run_op("divu_after_reset", 2'b11, 32'd1000, 32'd7, model(2'b11, 32'd1000, 32'd7), 0, 0, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: src_a  input  32  rs operand from register-file Read_data1; dividend for DIV/DIVU.
REQ-006 SHALL have port: src_b  input  32  rt operand from register-file Read_data2; divisor for DIV/DIVU.
REQ-007 SHALL have port: mthi  input  1  load HI from src_a.
REQ-008 SHALL have port: mtlo  input  1  load LO from src_a.
REQ-009 SHALL have port: hi  output  32  HI register, feeds MFHI writeback data.
REQ-010 SHALL have port: lo  output  32  LO register, feeds MFLO writeback data.
REQ-011 SHALL have port: busy  output  1  operation in progress; core stalls MFHI/MFLO/MULT/DIV while high.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when new hi/lo are visible.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; busy=1 exactly in CALC and FIX.
REQ-014 IDLE with start=1 at edge SHALL latch op, src_a, src_b, take operand magnitudes for signed ops, clear iteration counter, go to CALC.
REQ-015 CALC SHALL perform one iteration per cycle for exactly 32 cycles: shift-add for multiply, restoring shift-subtract for divide, on 32-bit magnitudes with a 64-bit accumulator/remainder.
REQ-016 After the 32nd CALC cycle SHALL enter FIX for 1 cycle, apply sign correction, write hi/lo at the edge leaving FIX, return to IDLE.
REQ-017 done SHALL be 1 for exactly the one cycle following the FIX exit edge; hi/lo SHALL hold the new result from that cycle on.
REQ-018 Latency: start sampled at edge N -> busy=1 in cycles N+1..N+33, done=1 and result visible in cycle N+34, busy=0 in that cycle.
REQ-019 MULT/MULTU SHALL produce {hi,lo} = full 64-bit product, signed (two's complement) or unsigned.
REQ-020 DIV/DIVU SHALL produce lo=quotient, hi=remainder; signed quotient truncates toward zero, signed remainder takes the sign of the dividend.
REQ-021 Divisor zero (any divide op) SHALL give hi=src_a, lo=32'hFFFFFFFF, with full 34-cycle latency.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-023 start while busy=1 SHALL be ignored (no queueing, latched operands unchanged).
REQ-024 mthi/mtlo in IDLE SHALL load hi/lo from src_a at the edge; both asserted loads both; done not asserted.
REQ-025 mthi/mtlo while busy=1 SHALL be ignored.
REQ-026 start and mthi/mtlo in same IDLE cycle: start SHALL win, mthi/mtlo ignored.
REQ-027 hi/lo SHALL be unchanged during CALC/FIX (old values readable until done).

Reset
REQ-028 rst=0 SHALL set state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
REQ-029 rst=0 mid-operation SHALL abort it; no partial result written; after rst=1 block accepts start on next edge.

Verification
REQ-030 MULT src_a=32'hFFFFFFFD (-3), src_b=7 -> cycle N+34: done=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-031 MULTU src_a=src_b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; busy high exactly 33 cycles.
REQ-032 DIV src_a=32'hFFFFFFF9 (-7), src_b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100/0 -> hi=100, lo=32'hFFFFFFFF.
REQ-033 start with MULTU 5*5 then start again at cycle N+10 with different operands -> only first result (lo=25, hi=0), single done pulse.
REQ-034 mthi src_a=32'h12345678 in IDLE, then mtlo src_a=32'h9 -> hi=32'h12345678, lo=9, done=0; mthi during busy -> hi unchanged.
REQ-035 rst=0 asserted asynchronously at cycle N+15 of a DIV -> busy=0, hi=lo=0 immediately; no done pulse afterwards.
